// File: rtl/ramp_sequencer.sv
// ramp_sequencer: drives an external up/down counter through a number of
// bottom<->top passes, starting from a preloaded value.
module ramp_sequencer #(
    parameter int W  = 4,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  start_val,
    input  logic [W-1:0]  top,
    input  logic [W-1:0]  bottom,
    input  logic [PW-1:0] passes,
    input  logic [W-1:0]  ctr_count,
    output logic          ctr_load,
    output logic [W-1:0]  ctr_value,
    output logic          ctr_up,
    output logic          ctr_down,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  start_q, top_q, bottom_q;
    logic [PW-1:0] rem_q;
    logic          err_q;
    logic          cfg_ok;
    logic          accept;
    logic          reject;
    logic          pass_end;

    assign cfg_ok   = (bottom <= start_val) && (start_val <= top) && (passes != '0);
    assign accept   = (state == IDLE) && start && cfg_ok;
    assign reject   = (state == IDLE) && start && !cfg_ok;
    assign pass_end = (state == DOWN) && !abort && (ctr_count == bottom_q);

    assign ctr_value = start_q;
    assign err       = err_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Latched configuration, remaining-pass count and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= '0;
            top_q    <= '0;
            bottom_q <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            start_q  <= start_val;
            top_q    <= top;
            bottom_q <= bottom;
            rem_q    <= passes;
            err_q    <= 1'b0;
        end else if (reject) begin
            err_q    <= 1'b1;
        end else if (pass_end) begin
            rem_q    <= rem_q - PW'(1);
        end
    end

    // Next-state and counter command decode; abort suppresses all commands.
    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_up    = 1'b0;
        ctr_down  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (abort) state_nxt = IDLE;
                else begin
                    ctr_load  = 1'b1;
                    state_nxt = UP;
                end
            end
            UP: begin
                busy = 1'b1;
                if (abort)                  state_nxt = IDLE;
                else if (ctr_count == top_q) state_nxt = DOWN;
                else                         ctr_up    = 1'b1;
            end
            DOWN: begin
                busy = 1'b1;
                if (abort)                     state_nxt = IDLE;
                else if (ctr_count == bottom_q) state_nxt = (rem_q == PW'(1)) ? DONE : UP;
                else                            ctr_down  = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: directed table plus hand-written corner sequences,
// with a behavioural up/down counter closing the loop around the DUT.
module tb_ramp_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] start_val = '0;
    logic [3:0] top = '0;
    logic [3:0] bottom = '0;
    logic [3:0] passes = '0;
    logic [3:0] ctr_count = '0;
    logic       ctr_load, ctr_up, ctr_down, busy, done, err;
    logic [3:0] ctr_value;

    int checks = 0;
    int failures = 0;

    ramp_sequencer #(.W(4), .PW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .start_val(start_val), .top(top), .bottom(bottom), .passes(passes),
        .ctr_count(ctr_count), .ctr_load(ctr_load), .ctr_value(ctr_value),
        .ctr_up(ctr_up), .ctr_down(ctr_down), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Controlled counter: applies a command at the edge that samples it.
    always @(posedge clk) begin
        if (ctr_load)      ctr_count <= ctr_value;
        else if (ctr_up)   ctr_count <= ctr_count + 4'd1;
        else if (ctr_down) ctr_count <= ctr_count - 4'd1;
    end

    typedef struct {
        logic       s, a;
        logic [3:0] sv, t, b, p;
        logic       e_load, e_up, e_dn, e_busy, e_done, e_err;
        logic [3:0] e_val, e_cnt;
    } vec_t;

    vec_t       tbl[12];
    logic [3:0] e40[12];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic [3:0] sv,
                         input logic [3:0] t, input logic [3:0] b, input logic [3:0] p);
        @(negedge clk);
        start = s; abort = a; start_val = sv; top = t; bottom = b; passes = p;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic chk_cmds(input string nm, input logic l, input logic u, input logic d);
        chk1({nm, ".load"}, ctr_load, l);
        chk1({nm, ".up"},   ctr_up,   u);
        chk1({nm, ".down"}, ctr_down, d);
    endtask

    initial begin
        // start=2 top=4 bottom=1 passes=1, with ignored starts in DOWN and DONE
        tbl[0]  = '{1'b1,1'b0,4'd2,4'd4,4'd1,4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0,4'd0};
        tbl[1]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 4'd2,4'd0};
        tbl[2]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 4'd2,4'd2};
        tbl[3]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 4'd2,4'd3};
        tbl[4]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'd2,4'd4};
        tbl[5]  = '{1'b1,1'b0,4'd9,4'd3,4'd5,4'd1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'd2,4'd4};
        tbl[6]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'd2,4'd3};
        tbl[7]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'd2,4'd2};
        tbl[8]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'd2,4'd1};
        tbl[9]  = '{1'b1,1'b1,4'd0,4'd0,4'd0,4'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'd2,4'd1};
        tbl[10] = '{1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'd2,4'd1};
        tbl[11] = '{1'b0,1'b1,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'd2,4'd1};
        e40 = '{4'd0,4'd1,4'd2,4'd2,4'd1,4'd0,4'd0,4'd1,4'd2,4'd2,4'd1,4'd0};

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk_cmds("rst", 1'b0, 1'b0, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.done", done, 1'b0);
        chk1("rst.err",  err,  1'b0);
        chk4("rst.value", ctr_value, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven basic sequence
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].s, tbl[i].a, tbl[i].sv, tbl[i].t, tbl[i].b, tbl[i].p);
            chk_cmds($sformatf("vec%0d", i), tbl[i].e_load, tbl[i].e_up, tbl[i].e_dn);
            chk1($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
            chk1($sformatf("vec%0d.done", i), done, tbl[i].e_done);
            chk1($sformatf("vec%0d.err", i),  err,  tbl[i].e_err);
            chk4($sformatf("vec%0d.value", i), ctr_value, tbl[i].e_val);
            chk4($sformatf("vec%0d.count", i), ctr_count, tbl[i].e_cnt);
        end

        // Illegal configs set err without touching the latched config
        drive(1'b1, 1'b0, 4'd4, 4'd3, 4'd5, 4'd1);
        chk1("bad1.err_pre", err, 1'b0);
        idle_cycle();
        chk1("bad1.err", err, 1'b1);
        chk1("bad1.busy", busy, 1'b0);
        chk_cmds("bad1", 1'b0, 1'b0, 1'b0);
        chk4("bad1.value", ctr_value, 4'd2);
        drive(1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0);
        idle_cycle();
        chk1("bad2.err", err, 1'b1);
        chk1("bad2.busy", busy, 1'b0);
        chk4("bad2.value", ctr_value, 4'd2);

        // Legal start clears err; two passes over 0..2
        drive(1'b1, 1'b0, 4'd0, 4'd2, 4'd0, 4'd2);
        chk1("p2.err_sticky", err, 1'b1);
        idle_cycle();
        chk1("p2.err_clr", err, 1'b0);
        chk1("p2.load", ctr_load, 1'b1);
        chk4("p2.value", ctr_value, 4'd0);
        for (int i = 0; i < 12; i++) begin
            idle_cycle();
            chk4($sformatf("p2.count%0d", i), ctr_count, e40[i]);
            chk1($sformatf("p2.busy%0d", i), busy, 1'b1);
            chk1($sformatf("p2.done%0d", i), done, 1'b0);
        end
        idle_cycle();
        chk1("p2.done", done, 1'b1);
        chk1("p2.done_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk1($sformatf("p2.after%0d", i), done, 1'b0);
        end

        // Abort in the second UP cycle
        drive(1'b1, 1'b0, 4'd1, 4'd5, 4'd0, 4'd1);
        idle_cycle();
        chk1("ab.load", ctr_load, 1'b1);
        idle_cycle();
        chk1("ab.up1", ctr_up, 1'b1);
        chk4("ab.cnt1", ctr_count, 4'd1);
        drive(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        chk_cmds("ab.cyc", 1'b0, 1'b0, 1'b0);
        chk4("ab.cnt2", ctr_count, 4'd2);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk1($sformatf("ab.busy%0d", i), busy, 1'b0);
            chk1($sformatf("ab.done%0d", i), done, 1'b0);
            chk4($sformatf("ab.cnt%0d", i + 3), ctr_count, 4'd2);
        end

        // top == bottom == start_val: 2 cycles per pass, no up/down
        drive(1'b1, 1'b0, 4'd7, 4'd7, 4'd7, 4'd3);
        idle_cycle();
        chk1("eq.load", ctr_load, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            idle_cycle();
            chk1($sformatf("eq.up%0d", k),   ctr_up,   1'b0);
            chk1($sformatf("eq.down%0d", k), ctr_down, 1'b0);
            chk1($sformatf("eq.done%0d", k), done, (k == 7) ? 1'b1 : 1'b0);
            chk1($sformatf("eq.busy%0d", k), busy, (k < 7) ? 1'b1 : 1'b0);
        end

        // Reset during DOWN; start while busy is ignored
        drive(1'b1, 1'b0, 4'd2, 4'd4, 4'd1, 4'd1);
        idle_cycle();
        chk1("rd.load", ctr_load, 1'b1);
        drive(1'b1, 1'b0, 4'd9, 4'd9, 4'd0, 4'd5);
        chk1("rd.up", ctr_up, 1'b1);
        chk4("rd.value", ctr_value, 4'd2);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        chk1("rd.down", ctr_down, 1'b1);
        chk4("rd.cnt", ctr_count, 4'd4);
        reset = 1'b1;
        #1;
        chk_cmds("rd.rst", 1'b0, 1'b0, 1'b0);
        chk1("rd.rst.busy", busy, 1'b0);
        chk1("rd.rst.done", done, 1'b0);
        chk4("rd.rst.value", ctr_value, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk1($sformatf("rd.done%0d", i), done, 1'b0);
            chk1($sformatf("rd.busy%0d", i), busy, 1'b0);
        end
        drive(1'b1, 1'b0, 4'd3, 4'd5, 4'd1, 4'd1);
        idle_cycle();
        chk1("rd.restart.load", ctr_load, 1'b1);
        chk4("rd.restart.value", ctr_value, 4'd3);
        chk1("rd.restart.busy", busy, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ramp_sequencer.md
RAMP_SEQUENCER -- requirements
Module: ramp_sequencer

Interface
REQ-001 Parameter W, default 4, counter data width.
REQ-002 Parameter PW, default 4, pass-count width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request to begin a sequence; sampled only in IDLE.
REQ-006 abort  in  1  terminate an active sequence.
REQ-007 start_val  in  W  counter preload value, latched on accepted start.
REQ-008 top  in  W  upper turn-around value, latched on accepted start.
REQ-009 bottom  in  W  lower turn-around value, latched on accepted start.
REQ-010 passes  in  PW  number of up+down passes, latched on accepted start.
REQ-011 ctr_count  in  W  current value of the controlled up/down counter.
REQ-012 ctr_load  out  1  load command to the counter.
REQ-013 ctr_value  out  W  load data to the counter; equals latched start_val.
REQ-014 ctr_up  out  1  increment command to the counter.
REQ-015 ctr_down  out  1  decrement command to the counter.
REQ-016 busy  out  1  high in LOAD, UP and DOWN.
REQ-017 done  out  1  one-cycle pulse on normal completion.
REQ-018 err  out  1  sticky configuration error flag.

Function
REQ-019 The block SHALL be an FSM with states IDLE, LOAD, UP, DOWN and DONE; the counter is assumed to apply a command at the same edge that samples it.
REQ-020 In IDLE, start=1 with bottom<=start_val<=top and passes!=0 SHALL latch the config, clear err, clear done, and enter LOAD.
REQ-021 In IDLE, start=1 with an illegal config SHALL set err=1, leave the latched config unchanged, and stay in IDLE.
REQ-022 err SHALL remain set until the next legal start or reset.
REQ-023 In LOAD, ctr_load=1 SHALL hold for exactly one cycle; the next state SHALL be UP.
REQ-024 In UP, ctr_up SHALL equal (ctr_count!=top).
REQ-025 In UP, ctr_count==top SHALL cause a transition to DOWN, with no increment issued that cycle.
REQ-026 In DOWN, ctr_down SHALL equal (ctr_count!=bottom).
REQ-027 In DOWN, ctr_count==bottom SHALL decrement the remaining-pass count; the next state SHALL be DONE if the remaining count was 1, else UP.
REQ-028 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-029 ctr_load, ctr_up and ctr_down SHALL be mutually exclusive and zero in IDLE and DONE.
REQ-030 start outside IDLE SHALL be ignored, including in DONE.
REQ-031 abort=1 in LOAD, UP or DOWN SHALL combinationally force all counter commands to 0 that cycle and enter IDLE with no done pulse.
REQ-032 abort=1 in IDLE or DONE SHALL have no effect.
REQ-033 top==bottom SHALL be legal; each pass then takes 2 cycles and issues no up/down commands.
REQ-034 Comparisons SHALL be unsigned and W bits wide.
REQ-035 The counter SHALL never be commanded beyond top or below bottom, so counter wrap-around never occurs.

Reset
REQ-036 reset=1 SHALL immediately force IDLE with busy, done, err, ctr_load, ctr_up, ctr_down and ctr_value all 0, latched config 0, and remaining passes 0.
REQ-037 Reset mid-sequence SHALL abandon the sequence with no done pulse.
REQ-038 After reset deasserts, the first legal start SHALL behave as REQ-020.

Verification
REQ-039 Start in cycle 0 with start_val=2, top=4, bottom=1, passes=1 -> ctr_load in cycle 1; ctr_count sequence 2,3,4,4,3,2,1 over cycles 2-8; done=1 in cycle 9; IDLE in cycle 10.
REQ-040 passes=2, start_val=bottom=0, top=2 -> ctr_count goes 0,1,2,2,1,0,0,1,2,2,1,0; exactly one done pulse.
REQ-041 start with bottom=5, top=3 -> err=1, busy=0, no commands issued; a following legal start clears err.
REQ-042 abort in the second UP cycle -> no command that cycle, IDLE next cycle, ctr_count frozen, done=0.
REQ-043 top=bottom=start_val=7, passes=3 -> ctr_up and ctr_down never asserted; done exactly 7 cycles after LOAD.
REQ-044 reset asserted during DOWN -> outputs 0 at once, done never pulses; start pulses while busy are ignored.
